apa102_in: RTL

Receiver for the APA102 clock/data LED protocol: the reading end of the stream our `apa102_out` drivers produce. It recovers 32-bit frames from an external controller's CLOCK/DATA pair and writes LED frames as 16-bit words onto the SRAM write bus, the same port `spi_in` drives. Use it to chain boards or to capture upstream pixel data into the shared frame memory that the outputs read.

---
 rtl/apa102_pkg.sv | 16 +
 rtl/apa102_in_if.sv | 22 ++
 rtl/apa102_in_sync_edge.sv | 47 ++++
 rtl/apa102_in.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/apa102_pkg.sv
// rtl/apa102_pkg.sv - shared types and protocol constants for the APA102 receiver
package apa102_pkg;

  typedef enum logic [1:0] {
    HUNT,
    SYNCED,
    FRAME
  } state_t;

  localparam int START_ZERO_BITS = 32;
  localparam int FRAME_BITS      = 32;

  localparam logic [2:0]  LED_HEADER = 3'b111;
  localparam logic [31:0] END_FRAME  = 32'hFFFF_FFFF;

endpackage

// File: rtl/apa102_in_if.sv
// rtl/apa102_in_if.sv - SRAM word write bus driven by the APA102 receiver
interface apa102_in_if #(
  parameter int ADDRESS_BUS_WIDTH = 16
);

  logic [ADDRESS_BUS_WIDTH-1:0] write_address;
  logic [15:0]                  write_data;
  logic                         write_strobe;

  modport master (
    output write_address,
    output write_data,
    output write_strobe
  );

  modport slave (
    input write_address,
    input write_data,
    input write_strobe
  );

endinterface

// File: rtl/apa102_in_sync_edge.sv
// rtl/apa102_in_sync_edge.sv - 2-FF synchronizers and clock_in rising-edge detect
// APA102_IN_TIMEOUT_EN adds a clock_edge output (either edge) for the idle counter.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic clock_in,
  input  logic data_in,
  output logic bit_valid,
  output logic data_bit
`ifdef APA102_IN_TIMEOUT_EN
  ,
  output logic clock_edge
`endif
);

  logic clk_meta;
  logic clk_sync;
  logic clk_prev;
  logic dat_meta;
  logic dat_sync;

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_meta  <= 1'b0;
      clk_sync  <= 1'b0;
      clk_prev  <= 1'b0;
      dat_meta  <= 1'b0;
      dat_sync  <= 1'b0;
      bit_valid <= 1'b0;
      data_bit  <= 1'b0;
    end else begin
      clk_meta  <= clock_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      dat_meta  <= data_in;
      dat_sync  <= dat_meta;
      // Data travels the same two stages as the clock, so it is aligned to the edge
      bit_valid <= clk_sync & ~clk_prev;
      data_bit  <= dat_sync;
    end
  end

`ifdef APA102_IN_TIMEOUT_EN
  assign clock_edge = clk_sync ^ clk_prev;
`endif

endmodule

// File: rtl/apa102_in.sv
// rtl/apa102_in.sv - APA102 clock/data receiver writing LED frames as 16-bit SRAM words
// APA102_IN_TIMEOUT_EN enables the idle timeout that abandons stalled sequences.
module apa102_in
  import apa102_pkg::*;
#(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int TIMEOUT_CYCLES    = 4800
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clock_in,
  input  logic                         data_in,
  input  logic [ADDRESS_BUS_WIDTH-1:0] start_address,
  input  logic [ADDRESS_BUS_WIDTH-1:0] word_limit,
  apa102_in_if.master                  wr,
  output logic                         frame_done_strobe,
  output logic [ADDRESS_BUS_WIDTH-1:0] word_count,
  output logic                         overflow,
  output logic                         error_strobe
);

  localparam int AW = ADDRESS_BUS_WIDTH;

  logic bit_valid;
  logic data_bit;

`ifdef APA102_IN_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic              clock_edge;
  logic [IDLE_W-1:0] idle_cnt;

  sync_edge u_sync (
    .clk        (clk),
    .rst        (rst),
    .clock_in   (clock_in),
    .data_in    (data_in),
    .bit_valid  (bit_valid),
    .data_bit   (data_bit),
    .clock_edge (clock_edge)
  );
`else
  sync_edge u_sync (
    .clk       (clk),
    .rst       (rst),
    .clock_in  (clock_in),
    .data_in   (data_in),
    .bit_valid (bit_valid),
    .data_bit  (data_bit)
  );
`endif

  state_t        state;
  logic [4:0]    zero_cnt;
  logic [4:0]    bit_cnt;
  logic [30:0]   shift;
  logic [AW-1:0] index;
  logic [AW-1:0] base;
  logic [AW-1:0] limit;
  logic [AW-1:0] low_index;
  logic [15:0]   low_word;
  logic          low_pending;

  logic [31:0]   frame_next;
  logic [AW-1:0] stored_count;

  assign frame_next   = {shift, data_bit};
  assign stored_count = (index < limit) ? index : limit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= HUNT;
      zero_cnt          <= '0;
      bit_cnt           <= '0;
      shift             <= '0;
      index             <= '0;
      base              <= '0;
      limit             <= '0;
      low_index         <= '0;
      low_word          <= '0;
      low_pending       <= 1'b0;
      wr.write_address  <= '0;
      wr.write_data     <= '0;
      wr.write_strobe   <= 1'b0;
      frame_done_strobe <= 1'b0;
      word_count        <= '0;
      overflow          <= 1'b0;
      error_strobe      <= 1'b0;
`ifdef APA102_IN_TIMEOUT_EN
      idle_cnt          <= '0;
`endif
    end else begin
      wr.write_strobe   <= 1'b0;
      frame_done_strobe <= 1'b0;
      error_strobe      <= 1'b0;

      // Second word of an LED frame always goes out in its own cycle
      if (low_pending) begin
        low_pending <= 1'b0;
        if (low_index < limit) begin
          wr.write_strobe  <= 1'b1;
          wr.write_address <= base + low_index;
          wr.write_data    <= low_word;
        end else begin
          overflow <= 1'b1;
        end
      end

`ifdef APA102_IN_TIMEOUT_EN
      if (clock_edge || state == HUNT) begin
        idle_cnt <= '0;
      end else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        idle_cnt <= '0;
        state    <= HUNT;
        zero_cnt <= '0;
        if (index != '0) begin
          frame_done_strobe <= 1'b1;
          word_count        <= stored_count;
        end
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
`endif

      if (bit_valid) begin
        case (state)
          HUNT: begin
            if (data_bit) begin
              zero_cnt <= '0;
            end else if (zero_cnt == 5'(START_ZERO_BITS - 1)) begin
              zero_cnt <= '0;
              index    <= '0;
              overflow <= 1'b0;
              base     <= start_address;
              limit    <= word_limit;
              state    <= SYNCED;
            end else begin
              zero_cnt <= zero_cnt + 1'b1;
            end
          end

          SYNCED: begin
            if (data_bit) begin
              shift    <= 31'd1;
              bit_cnt  <= 5'd1;
              zero_cnt <= '0;
              state    <= FRAME;
            end else if (zero_cnt == 5'(START_ZERO_BITS - 1)) begin
              // A fresh start frame closes any open sequence and restarts it
              if (index != '0) begin
                frame_done_strobe <= 1'b1;
                word_count        <= stored_count;
              end
              zero_cnt <= '0;
              index    <= '0;
              overflow <= 1'b0;
              base     <= start_address;
              limit    <= word_limit;
            end else begin
              zero_cnt <= zero_cnt + 1'b1;
            end
          end

          FRAME: begin
            shift   <= frame_next[30:0];
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 5'(FRAME_BITS - 1)) begin
              if (frame_next == END_FRAME) begin
                frame_done_strobe <= 1'b1;
                word_count        <= stored_count;
                zero_cnt          <= '0;
                state             <= HUNT;
              end else if (frame_next[31:29] == LED_HEADER) begin
                if (index < limit) begin
                  wr.write_strobe  <= 1'b1;
                  wr.write_address <= base + index;
                  wr.write_data    <= frame_next[31:16];
                end else begin
                  overflow <= 1'b1;
                end
                low_pending <= 1'b1;
                low_index   <= index + 1'b1;
                low_word    <= frame_next[15:0];
                index       <= index + AW'(2);
                state       <= SYNCED;
              end else begin
                error_strobe <= 1'b1;
                zero_cnt     <= '0;
                state        <= HUNT;
              end
            end
          end

          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
